// File: rtl/fetch_pc_stage.sv
// Fetch front end: PC register, next-PC selection and the IF/ID pipeline register.
// Also keeps a sticky fetch_err flag for misaligned or out-of-range fetch addresses.
module fetch_pc_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clr_d,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] pc4_in,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_f,
    output logic [31:0] ir_d,
    output logic [31:0] pc4_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        fetch_err
);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_JR     = 2'b11;

    // Last byte address still inside the instruction memory.
    localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd1;

    logic [31:0] r_pcF;
    logic [31:0] r_irD;
    logic [31:0] r_pc4D;
    logic [31:0] r_pc8D;
    logic        r_validD;
    logic        r_fetchErr;

    logic [31:0] w_npcRaw;
    logic [31:0] w_npc;
    logic        w_misaligned;
    logic        w_outOfRange;

    always_comb begin
        w_npcRaw = pc4_in;
        unique case (npc_sel)
            SEL_SEQ:    w_npcRaw = pc4_in;
            SEL_BRANCH: w_npcRaw = br_taken ? br_target : pc4_in;
            SEL_JUMP:   w_npcRaw = j_target;
            SEL_JR:     w_npcRaw = jr_target;
            default:    w_npcRaw = pc4_in;
        endcase
    end

    // The PC is always word aligned; a bad target is truncated rather than fetched.
    assign w_misaligned = |w_npcRaw[1:0];
    assign w_npc        = {w_npcRaw[31:2], 2'b00};
    assign w_outOfRange = (w_npc < PC_RESET) || (w_npc > PC_LAST);

    // Stall freezes everything, including the error flag, so a held-back target cannot flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcF      <= PC_RESET;
            r_irD      <= 32'd0;
            r_pc4D     <= 32'd0;
            r_pc8D     <= 32'd0;
            r_validD   <= 1'b0;
            r_fetchErr <= 1'b0;
        end else if (!stall) begin
            r_pcF  <= w_npc;
            r_pc4D <= pc4_in;
            r_pc8D <= pc4_in + 32'd4;
            if (clr_d) begin
                r_irD    <= 32'd0;
                r_validD <= 1'b0;
            end else begin
                r_irD    <= instr_in;
                r_validD <= 1'b1;
            end
            if (w_misaligned || w_outOfRange) begin
                r_fetchErr <= 1'b1;
            end
        end
    end

    assign pc_f      = r_pcF;
    assign ir_d      = r_irD;
    assign pc4_d     = r_pc4D;
    assign pc8_d     = r_pc8D;
    assign valid_d   = r_validD;
    assign fetch_err = r_fetchErr;

endmodule
